button_conditioner: RTL

Synchronises, debounces and edge-detects the raw board push-buttons before they reach the stopwatch/top-level control logic. Each channel produces a clean level, a one-cycle press pulse, a one-cycle release pulse and a one-shot long-press pulse, all in the `CLK` domain. It sits directly upstream of the stopwatch control `always` block. That block consumes `btn_press` for start/lap/stop/reset, replacing direct use of `BTN_N`/`BTN1..3`.

---
 rtl/button_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 130 +++++++++++++
 rtl/button_conditioner.sv | 35 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and 12 MHz board timing defaults for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 1 ms debounce and 1 s long-press at 12 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 12000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 12000000;

    // Counter width able to hold n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, press/release/long-press pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned LW = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);

    logic          sync1_q, sync2_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;

    // Polarity-normalised input into the CLK domain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                    press_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if ((lcnt_q == LCNT_LAST) && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else if (lcnt_q != LCNT_LAST) begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back to pressed keeps the long-press progress
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw board buttons into clean levels and one-cycle event pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned          N_BTN           = 4,
    parameter logic [N_BTN-1:0]     ACTIVE_LOW_MASK = 4'b0001,
    parameter int unsigned          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned          LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .CLK           (CLK),
            .RST_N         (RST_N),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i])
        );
    end

endmodule
